// File: rtl/aes_job_scheduler_if.sv
// Handshake bundle between the host-side requesters, the AES job scheduler
// and the shared SPI AES engine.
//   req0_* / req1_*   : job requests (valid/ready, mode, input block)
//   resp0_* / resp1_* : results back to each requester (valid/ready, data, err)
//   eng_*             : launch/result signals of the shared engine
// Modports: slave = scheduler side, master = requesters + engine side.
interface aes_job_scheduler_if #(
  parameter int DW = 128
);
  logic          req0_valid, req0_ready, req0_dec;
  logic [DW-1:0] req0_data;
  logic          resp0_valid, resp0_ready, resp0_err;
  logic [DW-1:0] resp0_data;
  logic          req1_valid, req1_ready, req1_dec;
  logic [DW-1:0] req1_data;
  logic          resp1_valid, resp1_ready, resp1_err;
  logic [DW-1:0] resp1_data;
  logic          eng_start, eng_dec, eng_done;
  logic [DW-1:0] eng_data_in, eng_data_out;

  modport slave (
    input  req0_valid, req0_dec, req0_data, resp0_ready,
    input  req1_valid, req1_dec, req1_data, resp1_ready,
    input  eng_done, eng_data_out,
    output req0_ready, resp0_valid, resp0_data, resp0_err,
    output req1_ready, resp1_valid, resp1_data, resp1_err,
    output eng_start, eng_dec, eng_data_in
  );

  modport master (
    output req0_valid, req0_dec, req0_data, resp0_ready,
    output req1_valid, req1_dec, req1_data, resp1_ready,
    output eng_done, eng_data_out,
    input  req0_ready, resp0_valid, resp0_data, resp0_err,
    input  req1_ready, resp1_valid, resp1_data, resp1_err,
    input  eng_start, eng_dec, eng_data_in
  );
endinterface

// File: rtl/aes_job_scheduler.sv
// Round-robin scheduler putting encrypt/decrypt jobs from two requesters onto
// one shared AES SPI engine. One job in flight: accept -> launch -> wait for
// done -> hand the result back to its owner -> accept the next job.
// Ports:
//   clk_master : single clock, rising edge
//   rst        : synchronous reset, active low
//   bus        : aes_job_scheduler_if.slave (requests, responses, engine)
//   busy       : scheduler not idle
//   jobs_done  : completed responses, wraps at 16 bits
// Optional build macro AES_SCHED_TIMEOUT_EN adds an engine watchdog of
// TO_CYCLES busy cycles; an expired job returns err = 1 with zero data.
module aes_job_scheduler #(
  parameter int DW        = 128,
  parameter int TO_CYCLES = 4096,
  parameter int TO_W      = 13
) (
  input  logic               clk_master,
  input  logic               rst,
  aes_job_scheduler_if.slave bus,
  output logic               busy,
  output logic [15:0]        jobs_done
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;
  state_t state, state_nxt;

  logic [1:0]         req_vld, req_dec, req_rdy, resp_rdy, resp_vld, resp_err;
  logic [1:0][DW-1:0] req_dat, resp_dat;
  logic               last_grant, grant, owner, accept, to_hit, eng_start;
  logic               job_dec;
  logic [DW-1:0]      job_dat;

  // The watchdog counter must be able to represent TO_CYCLES.
  if ((64'd1 << TO_W) <= 64'(TO_CYCLES)) begin : g_to_w_check
    $error("aes_job_scheduler: 2**TO_W must exceed TO_CYCLES");
  end

  assign req_vld  = {bus.req1_valid, bus.req0_valid};
  assign req_dec  = {bus.req1_dec, bus.req0_dec};
  assign req_dat  = {bus.req1_data, bus.req0_data};
  assign resp_rdy = {bus.resp1_ready, bus.resp0_ready};

  // Single requester wins outright; on a tie (or nothing pending) the one
  // that did not finish last gets the grant.
  assign grant  = (req_vld == 2'b11 || req_vld == 2'b00) ? ~last_grant : req_vld[1];
  assign accept = (state == IDLE) && req_vld[grant];

  always_ff @(posedge clk_master) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    eng_start = 1'b0;
    resp_vld  = 2'b00;
    req_rdy   = 2'b00;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy       = 1'b0;
        req_rdy[0] = req_vld[0] && !grant;
        req_rdy[1] = req_vld[1] && grant;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        eng_start = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (bus.eng_done || to_hit) state_nxt = RESP;
      RESP: begin
        resp_vld[owner] = 1'b1;
        if (resp_rdy[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_master) begin
    if (!rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      job_dec    <= 1'b0;
      job_dat    <= '0;
      resp_dat   <= '0;
      jobs_done  <= '0;
    end else begin
      if (accept) begin
        owner   <= grant;
        job_dec <= req_dec[grant];
        job_dat <= req_dat[grant];
      end
      // A done in the same cycle as watchdog expiry still delivers real data.
      if (state == BUSY && bus.eng_done)  resp_dat[owner] <= bus.eng_data_out;
      else if (state == BUSY && to_hit)   resp_dat[owner] <= '0;
      if (state == RESP && resp_rdy[owner]) begin
        last_grant <= owner;
        jobs_done  <= jobs_done + 16'd1;
      end
    end
  end

`ifdef AES_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Cleared while launching so the first BUSY cycle sees 0.
  always_ff @(posedge clk_master) begin
    if (!rst)                to_cnt <= '0;
    else if (state == ISSUE) to_cnt <= '0;
    else if (state == BUSY)  to_cnt <= to_cnt + TO_W'(1);
  end

  assign to_hit = (state == BUSY) && (to_cnt == TO_W'(TO_CYCLES));

  always_ff @(posedge clk_master) begin
    if (!rst) resp_err <= '0;
    else if (state == BUSY) begin
      if (bus.eng_done)  resp_err[owner] <= 1'b0;
      else if (to_hit)   resp_err[owner] <= 1'b1;
    end
  end
`else
  assign to_hit   = 1'b0;
  assign resp_err = '0;
`endif

  assign bus.req0_ready  = req_rdy[0];
  assign bus.req1_ready  = req_rdy[1];
  assign bus.resp0_valid = resp_vld[0];
  assign bus.resp1_valid = resp_vld[1];
  assign bus.resp0_data  = resp_dat[0];
  assign bus.resp1_data  = resp_dat[1];
  assign bus.resp0_err   = resp_err[0];
  assign bus.resp1_err   = resp_err[1];
  assign bus.eng_start   = eng_start;
  assign bus.eng_dec     = job_dec;
  assign bus.eng_data_in = job_dat;
endmodule

// File: doc/aes_job_scheduler.md
Name: aes_job_scheduler

Overview:
- Arbitrates two independent requesters onto the single shared AES SPI engine, which is an SPI_Master instance with a static key.
- Each job is either an encrypt or a decrypt. The scheduler issues it to the engine, waits for completion, then returns the result to the job's owner.
- Sits between the host-side clients and the SPI_Master datapath and replaces the ad-hoc sequencing done in benches.

Parameters:
- DW, 128, data block width (one AES block).
- TO_CYCLES, 4096, engine watchdog limit in clk_master cycles (used only with TIMEOUT_EN).
- TO_W, 13, watchdog counter width; must satisfy 2^TO_W > TO_CYCLES.

Ports:
- clk_master  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  scheduler accepts requester 0's job this cycle.
- req0_dec  in  1  0 = encrypt, 1 = decrypt.
- req0_data  in  DW  input block.
- resp0_valid  out  1  result for requester 0 available.
- resp0_ready  in  1  requester 0 takes the result.
- resp0_data  out  DW  result block.
- resp0_err  out  1  job aborted (TIMEOUT_EN only, else 0).
- req1_* / resp1_*  same set as above, for requester 1.
- eng_start  out  1  one-cycle pulse that launches the engine.
- eng_dec  out  1  engine mode; held stable during the job.
- eng_data_in  out  DW  engine input; held stable during the job.
- eng_done  in  1  engine finished (done_out_Enc | done_out_Dec).
- eng_data_out  in  DW  engine result; valid while eng_done = 1.
- busy  out  1  state != IDLE.
- jobs_done  out  16  count of completed responses; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst = 0 sampled at an edge):
  - State goes to IDLE.
  - All outputs go to 0: eng_* = 0, resp*_valid/data/err = 0, jobs_done = 0.
  - last_grant is set to 1, so requester 0 wins the first tie.
- Reset mid-job: the job is abandoned and no response is produced. Resetting the engine is the integrator's responsibility.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - reqX_ready is combinational: high only in IDLE, and only for the granted requester.
  - Grant rule: if only one requester is valid, grant it. If both are valid, grant the one != last_grant (round-robin).
  - When the granted valid is high, the handshake completes: latch data, mode and owner, then go to ISSUE.
  - With no valid input, remain in IDLE.
- ISSUE:
  - eng_start = 1 for exactly this cycle.
  - eng_dec and eng_data_in are driven from the latched values and held until the next IDLE.
  - Go to BUSY.
- BUSY:
  - On eng_done = 1: capture eng_data_out into the owner's resp data and go to RESP.
  - eng_done is ignored in every other state, including the ISSUE cycle.
- RESP:
  - resp<owner>_valid = 1; data and err are held stable until the owner's resp_ready = 1.
  - When the response is taken: go to IDLE, set last_grant = owner, increment jobs_done.
  - The non-owner resp_valid stays 0.
- Timing: accept at cycle T, eng_start at T+1, BUSY from T+2. If eng_done is sampled at cycle D, resp_valid is high from D+1. The earliest next accept is the cycle after the response handshake.
- Requests arriving while not in IDLE see ready = 0; requesters must hold valid, data and mode until accepted.
- A requester may drop valid before acceptance with no effect.
- The non-granted requester's ready is never high in the same cycle as the granted one.

Optional Feature:
- Macro: AES_SCHED_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on entry to BUSY and increments every BUSY cycle.
  - If it reaches TO_CYCLES with no eng_done, go to RESP with resp_err = 1 and resp_data = 0.
  - If eng_done arrives in the same cycle the count reaches TO_CYCLES, the done wins: err = 0 and the real data is returned.
  - An aborted job still increments jobs_done.
- Undefined: no counter logic; BUSY waits indefinitely; resp*_err tied to 0.

Test Plan:
- Single encrypt on requester 0:
  - Stimulus: key = 000102...1e1f, req0_data = 00112233445566778899aabbccddeeff, req0_dec = 0.
  - Response: one eng_start pulse; resp0_data = 8ea2b7ca516745bfeafc49904b496089; resp0_err = 0; jobs_done = 1.
- Decrypt on requester 1:
  - Stimulus: req1_data = 8ea2b7ca516745bfeafc49904b496089, req1_dec = 1.
  - Response: resp1_data = 00112233445566778899aabbccddeeff; resp0_valid stays 0.
- Contention:
  - Stimulus: both valid continuously from reset, with three jobs each queued.
  - Response: grant order 0,1,0,1,0,1; never two readies in one cycle; jobs_done = 6.
- Backpressure:
  - Stimulus: hold resp0_ready = 0 for 20 cycles after resp0_valid rises.
  - Response: data stable; req1_ready stays 0 throughout; eng_start is not reasserted.
- Reset in BUSY:
  - Stimulus: drive rst = 0 for one cycle while the scheduler is in BUSY.
  - Response: busy = 0 and all outputs 0 on the next cycle; no response is produced; a subsequent job completes normally.
- With AES_SCHED_TIMEOUT_EN and TO_CYCLES = 16:
  - Stimulus: never assert eng_done.
  - Response: resp_valid rises 17 cycles after BUSY entry, with err = 1 and data = 0.
